// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port byte-addressed data memory.
// Stores retire into a small FIFO and drain on idle port cycles; loads bypass it unless they overlap.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_func3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic          fence,
    output logic          req_stall,
    output logic [31:0]   req_rdata,
    output logic          empty,
    output logic [2:0]    mem_func3,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_dataW,
    output logic          mem_MemRW,
    input  logic [31:0]   mem_dataR
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_READ,
        ACT_ENQ,
        ACT_DRAIN
    } act_t;

    logic [2:0]    ent_func3 [DEPTH];
    logic [AW-1:0] ent_addr  [DEPTH];
    logic [31:0]   ent_wdata [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    act_t act;
    logic stall_c;
    logic hit;

    function automatic logic [AW:0] acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return (AW+1)'(1);
            2'b01:   return (AW+1)'(2);
            default: return (AW+1)'(4);
        endcase
    endfunction

    // Ranges are compared one bit wider than the address so a+size cannot wrap.
    always_comb begin : overlap
        logic [PW-1:0] off;
        logic [AW:0]   req_lo;
        logic [AW:0]   req_hi;
        logic [AW:0]   ent_lo;
        logic [AW:0]   ent_hi;
        hit    = 1'b0;
        off    = '0;
        ent_lo = '0;
        ent_hi = '0;
        req_lo = {1'b0, req_addr};
        req_hi = req_lo + acc_size(req_func3);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off    = PW'(i) - head;
            ent_lo = {1'b0, ent_addr[i]};
            ent_hi = ent_lo + acc_size(ent_func3[i]);
            if (({1'b0, off} < count) && (req_lo < ent_hi) && (ent_lo < req_hi)) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin : decide
        act     = ACT_IDLE;
        stall_c = 1'b0;
        if (req_valid && !req_we) begin
            if (hit) begin
                act     = ACT_DRAIN;
                stall_c = 1'b1;
            end else begin
                act = ACT_READ;
            end
        end else if (req_valid && req_we) begin
            if (count == FULL) begin
                act     = ACT_DRAIN;
                stall_c = 1'b1;
            end else begin
                act = ACT_ENQ;
            end
        end else if (count != '0) begin
            act     = ACT_DRAIN;
            stall_c = fence;
        end
    end

    always_comb begin : port_drive
        req_stall = 1'b0;
        req_rdata = '0;
        mem_MemRW = 1'b0;
        mem_addr  = '0;
        mem_func3 = 3'b010;
        mem_dataW = '0;
        if (!rst) begin
            req_stall = stall_c;
            case (act)
                ACT_READ: begin
                    mem_func3 = req_func3;
                    mem_addr  = req_addr;
                    req_rdata = mem_dataR;
                end
                ACT_DRAIN: begin
                    mem_MemRW = 1'b1;
                    mem_func3 = ent_func3[head];
                    mem_addr  = ent_addr[head];
                    mem_dataW = ent_wdata[head];
                end
                default: ;
            endcase
        end
    end

    assign empty = rst || (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case (act)
                ACT_ENQ: begin
                    tail  <= tail + 1'b1;
                    count <= count + 1'b1;
                end
                ACT_DRAIN: begin
                    head  <= head + 1'b1;
                    count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && act == ACT_ENQ) begin
            ent_func3[tail] <= req_func3;
            ent_addr[tail]  <= req_addr;
            ent_wdata[tail] <= req_wdata;
        end
    end

`ifndef SYNTHESIS
    fence_only_when_idle: assert property (@(posedge clk) disable iff (rst)
        !(fence && req_valid));
    request_held_while_stalled: assert property (@(posedge clk) disable iff (rst)
        req_stall |=> $stable({req_valid, req_we, req_func3, req_addr, req_wdata}));
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: program-order memory reference, write/load scoreboards, directed and random traffic.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    req_func3 = 3'b010;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          fence = 1'b0;
    logic          req_stall;
    logic [31:0]   req_rdata;
    logic          empty;
    logic [2:0]    mem_func3;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_dataW;
    logic          mem_MemRW;
    logic [31:0]   mem_dataR;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata), .fence(fence),
        .req_stall(req_stall), .req_rdata(req_rdata), .empty(empty),
        .mem_func3(mem_func3), .mem_addr(mem_addr), .mem_dataW(mem_dataW),
        .mem_MemRW(mem_MemRW), .mem_dataR(mem_dataR)
    );

    always #5 clk = ~clk;

    // Physical memory (what the DUT actually wrote) and program-order reference memory.
    logic [7:0] pmem   [1024];
    logic [7:0] refmem [1024];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] lq[$];
    wr_t         wcur;
    logic [31:0] lcur;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int sz(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [2:0] f3, input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
        case (f3[1:0])
            2'b00:   return {24'b0, b0};
            2'b01:   return {16'b0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    logic [9:0] ma;
    assign ma = mem_addr[9:0];
    assign mem_dataR = pick(mem_func3, pmem[ma], pmem[ma + 10'd1], pmem[ma + 10'd2], pmem[ma + 10'd3]);

    function automatic logic [31:0] ref_read(input logic [2:0] f3, input logic [31:0] a);
        logic [9:0] i;
        i = a[9:0];
        return pick(f3, refmem[i], refmem[i + 10'd1], refmem[i + 10'd2], refmem[i + 10'd3]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every memory write and every completed load is checked against the scoreboards.
    always @(negedge clk) begin
        if (!rst && mem_MemRW) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wcur = wq.pop_front();
                check("wr_addr", mem_addr, wcur.addr);
                check("wr_data", mem_dataW, wcur.data);
                check("wr_func3", 32'(mem_func3), 32'(wcur.f3));
                for (int k = 0; k < sz(mem_func3); k++)
                    pmem[mem_addr[9:0] + 10'(k)] = mem_dataW[8*k +: 8];
            end
        end
        if (!rst && req_valid && !req_we && !req_stall) begin
            if (lq.size() == 0) begin
                check("unexpected_load", 32'd1, 32'd0);
            end else begin
                lcur = lq.pop_front();
                check("load_rdata", req_rdata, lcur);
            end
        end
    end

    task automatic idle(input int n);
        req_valid = 1'b0;
        fence     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output logic rw, output logic [31:0] maddr, output logic emp);
        if (we) begin
            wq.push_back(wr_t'{f3, a, d});
            for (int k = 0; k < sz(f3); k++) refmem[a[9:0] + 10'(k)] = d[8*k +: 8];
        end else begin
            lq.push_back(ref_read(f3, a));
        end
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = d;
        stalls    = 0;
        @(negedge clk);
        while (req_stall && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (req_stall) check("request_timeout", 32'd1, 32'd0);
        rw    = mem_MemRW;
        maddr = mem_addr;
        emp   = empty;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_fence(output int stalls, output int writes, output logic emp);
        fence  = 1'b1;
        stalls = 0;
        writes = 0;
        @(negedge clk);
        while (req_stall && stalls < 20) begin
            stalls++;
            if (mem_MemRW) writes++;
            @(negedge clk);
        end
        if (req_stall) check("fence_timeout", 32'd1, 32'd0);
        emp = empty;
        @(posedge clk);
        #1;
        fence = 1'b0;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 4 * DEPTH && !empty; i++) idle(1);
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, output int stalls);
        logic        rw;
        logic [31:0] ma_s;
        logic        emp;
        issue(1'b1, f3, a, d, stalls, rw, ma_s, emp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          wr;
        int          st5 [5];
        logic        rw;
        logic [31:0] maddr;
        logic        emp;
        int          kind;

        for (int i = 0; i < 1024; i++) begin
            pmem[i]   = 8'h00;
            refmem[i] = 8'h00;
        end

        // Outputs must be forced even with a request pending during reset.
        req_valid = 1'b1;
        req_addr  = 32'h44;
        req_func3 = 3'b000;
        @(negedge clk);
        check("rst_stall", 32'(req_stall), 32'd0);
        check("rst_memrw", 32'(mem_MemRW), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_func3", 32'(mem_func3), 32'd2);
        check("rst_dataw", mem_dataW, 32'd0);
        check("rst_rdata", req_rdata, 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b0;

        // Single store drains the following idle cycle.
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, st, rw, maddr, emp);
        check("sw_single_stall", 32'(st), 32'd0);
        check("sw_single_no_bypass", 32'(rw), 32'd0);
        @(negedge clk);
        check("sw_single_drain_rw", 32'(mem_MemRW), 32'd1);
        check("sw_single_drain_addr", mem_addr, 32'h100);
        check("sw_single_drain_data", mem_dataW, 32'hDEADBEEF);
        check("sw_single_drain_f3", 32'(mem_func3), 32'd2);
        check("sw_single_not_empty", 32'(empty), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sw_single_empty_after", 32'(empty), 32'd1);
        check("sw_single_port_idle", 32'(mem_MemRW), 32'd0);
        @(posedge clk);
        #1;

        // Five back-to-back stores: the fifth waits one cycle for the oldest to drain.
        for (int i = 0; i < 5; i++) store(3'b010, 32'(4 * i), $urandom, st5[i]);
        check("full_first4_stalls", 32'(st5[0] + st5[1] + st5[2] + st5[3]), 32'd0);
        check("full_5th_stall", 32'(st5[4]), 32'd1);
        drain_all();

        // Byte store overlapping a later word load.
        store(3'b000, 32'h203, 32'h000000AA, st);
        issue(1'b0, 3'b010, 32'h200, 32'h0, st, rw, maddr, emp);
        check("ovl_load_stall", 32'(st), 32'd1);
        check("ovl_load_read", 32'(rw), 32'd0);
        check("ovl_load_addr", maddr, 32'h200);
        drain_all();

        // Adjacent but disjoint load goes straight through.
        store(3'b010, 32'h300, 32'h12345678, st);
        issue(1'b0, 3'b001, 32'h304, 32'h0, st, rw, maddr, emp);
        check("noovl_load_stall", 32'(st), 32'd0);
        check("noovl_load_read", 32'(rw), 32'd0);
        check("noovl_load_addr", maddr, 32'h304);
        check("noovl_count_kept", 32'(emp), 32'd0);
        drain_all();

        // Fence with three buffered stores.
        for (int i = 0; i < 3; i++) store(3'b010, 32'h10 + 32'(4 * i), $urandom, st);
        do_fence(st, wr, emp);
        check("fence_stalls", 32'(st), 32'd3);
        check("fence_writes", 32'(wr), 32'd3);
        check("fence_empty", 32'(emp), 32'd1);

        // Reset while draining discards buffered stores.
        store(3'b010, 32'h20, 32'hCAFEF00D, st);
        store(3'b010, 32'h24, 32'h0BADC0DE, st);
        rst = 1'b1;
        @(negedge clk);
        check("rst_drain_no_write", 32'(mem_MemRW), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wq.delete();
        for (int i = 0; i < 1024; i++) refmem[i] = pmem[i];
        @(negedge clk);
        check("rst_drain_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        issue(1'b0, 3'b010, 32'h20, 32'h0, st, rw, maddr, emp);
        check("rst_load_no_stall", 32'(st), 32'd0);
        issue(1'b0, 3'b010, 32'h24, 32'h0, st, rw, maddr, emp);
        check("rst_load2_no_stall", 32'(st), 32'd0);

        // Random mix over a small window so overlaps are frequent.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 99);
            if (kind < 45) begin
                store(3'($urandom_range(0, 2)), 32'($urandom_range(0, 63)), $urandom, st);
                if (st > 1) check("rnd_store_stall_bound", 32'(st), 32'd1);
            end else if (kind < 80) begin
                issue(1'b0, 3'($urandom_range(0, 2)), 32'($urandom_range(0, 63)), 32'h0, st, rw, maddr, emp);
                if (st > DEPTH) check("rnd_load_stall_bound", 32'(st), 32'(DEPTH));
            end else if (kind < 90) begin
                idle($urandom_range(1, 3));
            end else begin
                do_fence(st, wr, emp);
                check("rnd_fence_empty", 32'(emp), 32'd1);
                check("rnd_fence_writes", 32'(wr), 32'(st));
            end
        end
        drain_all();
        idle(2);
        check("writes_outstanding", 32'(wq.size()), 32'd0);
        check("loads_outstanding", 32'(lq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
